layer_scheduler: RTL and testbench

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/nn_ctrl_pkg.sv | 17 +
 rtl/idx_counter.sv | 39 +++
 rtl/layer_scheduler.sv | 143 ++++++++++++++
 tb/tb_layer_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neural-layer control path: state encoding and sizing constants.
package nn_ctrl_pkg;

  localparam int unsigned IDX_W_DEF   = 8;
  localparam int unsigned ALU_LAT_MAX = 15;
  localparam int unsigned LAT_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/idx_counter.sv
// Index counter with clear, enable and terminal-count compare; it stops at last_i
// rather than wrapping, so an all-ones count never overflows.
module idx_counter
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned W = IDX_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         tc_o
);

  logic [W-1:0] idx_q, idx_d;

  assign tc_o  = (idx_q == last_i);
  assign idx_o = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i && !tc_o) begin
      idx_d = idx_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Sequences one layer pass: per neuron clear, accumulate inputs, drain the ALU pipe,
// store the result; outputs are decodes of the registered state and index counters.
module layer_scheduler
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [IDX_W-1:0] n_neurons,
  input  logic [IDX_W-1:0] n_inputs,
  output logic             ag_rst,
  output logic             ag_read,
  output logic             alu_rst,
  output logic             result_we,
  output logic [IDX_W-1:0] neuron_idx,
  output logic [IDX_W-1:0] input_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LAT_CL = (ALU_LAT > ALU_LAT_MAX) ? ALU_LAT_MAX : ALU_LAT;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LAT_CL == 0) ? 0 : LAT_CL - 1);
  // With no ALU latency the drain phase disappears and accumulation goes straight to store.
  localparam state_t POST_ACCUM = (LAT_CL == 0) ? S_STORE : S_DRAIN;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n_neurons_q, n_neurons_d;
  logic [IDX_W-1:0] n_inputs_q, n_inputs_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic n_clr, n_en, n_tc;
  logic i_clr, i_en, i_tc;

  idx_counter #(.W(IDX_W)) u_neuron_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (n_clr),
    .en_i   (n_en),
    .last_i (n_neurons_q - IDX_W'(1)),
    .idx_o  (neuron_idx),
    .tc_o   (n_tc)
  );

  idx_counter #(.W(IDX_W)) u_input_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (i_clr),
    .en_i   (i_en),
    .last_i (n_inputs_q - IDX_W'(1)),
    .idx_o  (input_idx),
    .tc_o   (i_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_neurons_q <= '0;
      n_inputs_q  <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      n_neurons_q <= n_neurons_d;
      n_inputs_q  <= n_inputs_d;
      lat_q       <= lat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_neurons_d = n_neurons_q;
    n_inputs_d  = n_inputs_q;
    lat_d       = '0;
    n_clr       = 1'b0;
    n_en        = 1'b0;
    i_en        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_neurons_d = n_neurons;
          n_inputs_d  = n_inputs;
          n_clr       = 1'b1;
          state_d     = (n_neurons == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = (n_inputs_q == '0) ? POST_ACCUM : S_ACCUM;
      end
      S_ACCUM: begin
        if (!hold) begin
          if (i_tc) begin
            state_d = POST_ACCUM;
          end else begin
            i_en = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_STORE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_STORE: begin
        if (n_tc) begin
          state_d = S_DONE;
        end else begin
          n_en    = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the pass without advancing either index.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      n_en    = 1'b0;
      i_en    = 1'b0;
    end

    i_clr = (state_d == S_CLEAR);
  end

  assign ag_rst    = reset || (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign alu_rst   = reset || (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign ag_read   = !reset && (state_q == S_ACCUM) && !hold;
  assign result_we = !reset && (state_q == S_STORE);
  assign busy      = !reset && (state_q != S_IDLE);
  assign done      = !reset && (state_q == S_DONE);

endmodule

// File: tb/tb_layer_scheduler.sv
// Randomized bench for layer_scheduler: a per-cycle expected trace is built from the pass
// structure (neurons x inputs, holds, drain, store) and compared against two DUT instances.
module tb_layer_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold  = 1'b0;
  logic [7:0] n_neurons = 8'd0;
  logic [7:0] n_inputs  = 8'd0;

  logic [1:0]      ag_rst_w, ag_read_w, alu_rst_w, we_w, busy_w, done_w;
  logic [1:0][7:0] nidx_w, iidx_w;

  layer_scheduler #(.IDX_W(8), .ALU_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .n_neurons(n_neurons), .n_inputs(n_inputs),
    .ag_rst(ag_rst_w[0]), .ag_read(ag_read_w[0]), .alu_rst(alu_rst_w[0]),
    .result_we(we_w[0]), .neuron_idx(nidx_w[0]), .input_idx(iidx_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  layer_scheduler #(.IDX_W(8), .ALU_LAT(0)) u_dut_lat0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .n_neurons(n_neurons), .n_inputs(n_inputs),
    .ag_rst(ag_rst_w[1]), .ag_read(ag_read_w[1]), .alu_rst(alu_rst_w[1]),
    .result_we(we_w[1]), .neuron_idx(nidx_w[1]), .input_idx(iidx_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  typedef struct {
    bit hold;
    bit ag_rst, ag_read, alu_rst, we, busy, done;
    int nidx, iidx;
    bit chk_n, chk_i;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   prev_i = 0;
  bit   prev_i_ok = 1'b1;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, want);
    end
  endtask

  function automatic exp_t ent(bit h, bit agr, bit rd, bit alr, bit we, bit bsy, bit dn,
                               int n, int i, bit cn, bit ci);
    exp_t e;
    e.hold = h; e.ag_rst = agr; e.ag_read = rd; e.alu_rst = alr; e.we = we;
    e.busy = bsy; e.done = dn; e.nidx = n; e.iidx = i; e.chk_n = cn; e.chk_i = ci;
    return e;
  endfunction

  // Reference pass: one entry per cycle after the start edge, ending with the IDLE cycle.
  task automatic build(input int nn, input int ni, input int lat, input int hold_pct,
                       input int forced, output int nh);
    int li;
    exp_q.delete();
    nh = 0;
    li = (ni == 0) ? 0 : ni - 1;
    for (int n = 0; n < nn; n++) begin
      exp_q.push_back(ent(1'($urandom), 1, 0, 1, 0, 1, 0, n, 0, 1, 1));
      for (int i = 0; i < ni; i++) begin
        int f;
        f = (n == 0 && i == 1) ? forced : 0;
        forever begin
          if (f > 0) f--;
          else if ($urandom_range(0, 99) >= hold_pct) break;
          exp_q.push_back(ent(1, 0, 0, 0, 0, 1, 0, n, i, 1, 1));
          nh++;
        end
        exp_q.push_back(ent(0, 0, 1, 0, 0, 1, 0, n, i, 1, 1));
      end
      for (int d = 0; d < lat; d++)
        exp_q.push_back(ent(1'($urandom), 0, 0, 0, 0, 1, 0, n, li, 1, 1));
      exp_q.push_back(ent(1'($urandom), 0, 0, 0, 1, 1, 0, n, li, 1, 1));
    end
    if (nn == 0) begin
      exp_q.push_back(ent(1'($urandom), 0, 0, 0, 0, 1, 1, 0, prev_i, 1, prev_i_ok));
      exp_q.push_back(ent(0, 1, 0, 1, 0, 0, 0, 0, prev_i, 1, prev_i_ok));
    end else begin
      exp_q.push_back(ent(1'($urandom), 0, 0, 0, 0, 1, 1, nn - 1, li, 1, 1));
      exp_q.push_back(ent(0, 1, 0, 1, 0, 0, 0, nn - 1, li, 1, 1));
    end
  endtask

  task automatic chk_idle(input int sel, input bit idx_zero);
    chk("idle_ag_rst",  int'(ag_rst_w[sel]),  1);
    chk("idle_alu_rst", int'(alu_rst_w[sel]), 1);
    chk("idle_ag_read", int'(ag_read_w[sel]), 0);
    chk("idle_we",      int'(we_w[sel]),      0);
    chk("idle_busy",    int'(busy_w[sel]),    0);
    chk("idle_done",    int'(done_w[sel]),    0);
    if (idx_zero) begin
      chk("idle_nidx", int'(nidx_w[sel]), 0);
      chk("idle_iidx", int'(iidx_w[sel]), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) chk_idle(s, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) chk_idle(s, 1'b1);
    prev_i = 0;
    prev_i_ok = 1'b1;
  endtask

  // kill_at: -1 none, -2 random abort point, else cycle index; kill_rst selects reset over abort.
  task automatic do_pass(input int sel, input int nn, input int ni, input int hold_pct,
                         input int forced, input int kill_at_i, input bit kill_rst,
                         input int noise_pct);
    int lat, nh, done_k, we_cnt, done_cnt, kill_at;
    bit killed;
    lat = (sel == 0) ? 1 : 0;
    build(nn, ni, lat, hold_pct, forced, nh);
    kill_at = (kill_at_i == -2) ? int'($urandom_range(0, exp_q.size() - 2)) : kill_at_i;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; hold = 1'($urandom);
    n_neurons = 8'(nn); n_inputs = 8'(ni);
    done_k = -1; we_cnt = 0; done_cnt = 0; killed = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      exp_t e;
      e = exp_q[k];
      @(negedge clk);
      hold  = e.hold;
      start = e.busy && ($urandom_range(0, 99) < noise_pct);
      if (e.busy && noise_pct > 0) begin
        n_neurons = 8'($urandom);
        n_inputs  = 8'($urandom);
      end
      abort = (k == kill_at) && !kill_rst;
      reset = (k == kill_at) && kill_rst;
      #1;
      if (reset) begin
        chk_idle(sel, 1'b0);
      end else begin
        chk("ag_rst",  int'(ag_rst_w[sel]),  int'(e.ag_rst));
        chk("ag_read", int'(ag_read_w[sel]), int'(e.ag_read));
        chk("alu_rst", int'(alu_rst_w[sel]), int'(e.alu_rst));
        chk("result_we", int'(we_w[sel]),    int'(e.we));
        chk("busy",    int'(busy_w[sel]),    int'(e.busy));
        chk("done",    int'(done_w[sel]),    int'(e.done));
        if (e.chk_n) chk("neuron_idx", int'(nidx_w[sel]), e.nidx);
        if (e.chk_i) chk("input_idx",  int'(iidx_w[sel]), e.iidx);
      end
      if (done_w[sel]) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (we_w[sel]) we_cnt++;
      if (k == kill_at) begin
        killed = 1'b1;
        break;
      end
    end
    if (killed) begin
      @(negedge clk);
      abort = 1'b0; reset = 1'b0; start = 1'b0;
      #1;
      chk_idle(sel, kill_rst);
      if (kill_at < exp_q.size() - 2) chk("done_after_kill", done_cnt, 0);
      prev_i = 0;
      prev_i_ok = kill_rst;
    end else begin
      chk("done_edge", done_k, nn * (ni + lat + 2) + nh);
      chk("done_count", done_cnt, 1);
      chk("we_count", we_cnt, nn);
      if (nn != 0) begin
        prev_i = (ni == 0) ? 0 : ni - 1;
        prev_i_ok = 1'b1;
      end
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // ALU_LAT=1 instance: directed passes first.
    do_pass(0, 2, 3, 0, 0, -1, 1'b0, 0);
    do_pass(0, 2, 3, 0, 2, -1, 1'b0, 0);
    do_pass(0, 2, 3, 0, 0, 8, 1'b0, 0);
    do_pass(0, 2, 3, 0, 0, -1, 1'b0, 0);
    do_pass(0, 2, 3, 0, 0, 4, 1'b1, 0);
    do_pass(0, 2, 3, 0, 0, -1, 1'b0, 100);
    for (int r = 0; r < 40; r++) begin
      do_pass(0, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 30, 0,
              ($urandom_range(0, 4) == 0) ? -2 : -1, 1'b0, 15);
    end

    // ALU_LAT=0 instance.
    do_reset();
    do_pass(1, 0, 3, 0, 0, -1, 1'b0, 0);
    do_pass(1, 1, 0, 0, 0, -1, 1'b0, 0);
    for (int r = 0; r < 30; r++) begin
      do_pass(1, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 30, 0,
              ($urandom_range(0, 4) == 0) ? -2 : -1, 1'b0, 15);
    end
    do_pass(1, 255, 255, 0, 0, -1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
